// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte-stream
// requesters. A grant covers a whole message (ending on req_last), bounded by a
// burst limit and an idle timeout. A single holding register feeds the UART.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int IDLE_TO   = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_vld,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_rdy,
  output logic [N_REQ-1:0]        grant,
  output logic [DATA_W-1:0]       uart_din,
  output logic                    uart_din_vld,
  input  logic                    uart_rfd,
  output logic                    busy
);

  localparam int IW  = $clog2(N_REQ);
  localparam int BCW = $clog2(MAX_BURST + 1);
  localparam int ICW = $clog2(IDLE_TO + 1);

  // After reset the pointer sits on the highest index so requester 0 wins first.
  localparam logic [IW-1:0]  LAST_RST  = IW'(N_REQ - 1);
  localparam logic [BCW-1:0] BURST_END = BCW'(MAX_BURST - 1);
  localparam logic [ICW-1:0] IDLE_END  = ICW'(IDLE_TO - 1);
  localparam logic [ICW-1:0] IDLE_SAT  = ICW'(IDLE_TO);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN
  } state_t;

  state_t             state;
  state_t             state_nx;

  logic [N_REQ-1:0]   grant_q;
  logic [IW-1:0]      gidx;
  logic [IW-1:0]      last_idx;
  logic [BCW-1:0]     byte_cnt;
  logic [ICW-1:0]     idle_cnt;
  logic [DATA_W-1:0]  hold_data;
  logic               hold_full;

  logic               pick_found;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      cand;

  logic [DATA_W-1:0]  sel_data;
  logic               sel_vld;
  logic               sel_last;
  logic               accept;

  // Idle counter stops at IDLE_TO so it can never wrap back below the timeout.
  function automatic logic [ICW-1:0] idle_sat_inc(input logic [ICW-1:0] v);
    return (v == IDLE_SAT) ? v : v + 1'b1;
  endfunction

  // Round-robin search starting one past the previous winner, with wrap.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(last_idx) + k) % N_REQ);
      if (!pick_found && req_vld[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Route the granted requester's byte, valid and last flag.
  always_comb begin
    sel_data = '0;
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gidx == IW'(i)) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
        sel_vld  = req_vld[i];
        sel_last = req_last[i];
      end
    end
  end

  // Next-state and handshake decode. req_rdy looks only at the registered
  // hold_full, so the holding register is never reloaded in the cycle it drains.
  always_comb begin
    state_nx = state;
    req_rdy  = '0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) state_nx = XFER;
      end
      XFER: begin
        req_rdy = hold_full ? '0 : grant_q;
        accept  = !hold_full && sel_vld;
        if (accept) begin
          if (sel_last || (byte_cnt == BURST_END)) state_nx = DRAIN;
        end else if (idle_cnt == IDLE_END) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (!hold_full) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Grant ownership and round-robin pointer; the grant is held through DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q  <= '0;
      gidx     <= '0;
      last_idx <= LAST_RST;
    end else if (state == IDLE && pick_found) begin
      grant_q  <= N_REQ'(1) << pick_idx;
      gidx     <= pick_idx;
      last_idx <= pick_idx;
    end else if (state == DRAIN && !hold_full) begin
      grant_q  <= '0;
    end
  end

  // Burst and idle counters for the current grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      idle_cnt <= '0;
    end else if (state == IDLE && pick_found) begin
      byte_cnt <= '0;
      idle_cnt <= '0;
    end else if (state == XFER) begin
      if (accept) begin
        byte_cnt <= byte_cnt + 1'b1;
        idle_cnt <= '0;
      end else if (!hold_full && !sel_vld) begin
        idle_cnt <= idle_sat_inc(idle_cnt);
      end
    end
  end

  // Single-entry holding register toward the UART; reset discards its content.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_data <= sel_data;
      hold_full <= 1'b1;
    end else if (hold_full && uart_rfd) begin
      hold_full <= 1'b0;
    end
  end

  assign grant        = grant_q;
  assign uart_din     = hold_data;
  assign uart_din_vld = hold_full;
  assign busy         = (state != IDLE) || hold_full;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte sources, a log of the
// bytes the UART takes (with their owner), and hand-computed expectations.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_vld;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_rdy;
  logic [N-1:0]   grant;
  logic [W-1:0]   uart_din;
  logic           uart_din_vld;
  logic           uart_rfd;
  logic           busy;

  uart_tx_arbiter #(
    .N_REQ    (N),
    .DATA_W   (W),
    .MAX_BURST(4),
    .IDLE_TO  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_data    (req_data),
    .req_vld     (req_vld),
    .req_last    (req_last),
    .req_rdy     (req_rdy),
    .grant       (grant),
    .uart_din    (uart_din),
    .uart_din_vld(uart_din_vld),
    .uart_rfd    (uart_rfd),
    .busy        (busy)
  );

  logic [8:0]  src_mem [N][16];
  int          src_len [N];
  int          src_ptr [N];
  logic [11:0] out_rec [64];
  int          out_n;
  int          n_checks;
  int          n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] oh_idx(input logic [N-1:0] oh);
    logic [3:0] r;
    r = 4'hF;
    for (int i = 0; i < N; i++) if (oh[i]) r = 4'(i);
    return r;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_ptr[i] < src_len[i]) begin
        req_vld[i]        = 1'b1;
        req_last[i]       = src_mem[i][src_ptr[i]][8];
        req_data[i*W +: W] = src_mem[i][src_ptr[i]][7:0];
      end else begin
        req_vld[i]        = 1'b0;
        req_last[i]       = 1'b0;
        req_data[i*W +: W] = '0;
      end
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l);
    src_mem[i][src_len[i]] = {l, d};
    src_len[i]++;
  endtask

  // One clock: sample handshakes on the falling edge, then advance sources.
  task automatic step();
    logic [N-1:0] acc;
    logic         take;
    logic [W-1:0] tdat;
    logic [3:0]   tsrc;
    @(negedge clk);
    acc  = req_vld & req_rdy;
    take = uart_din_vld & uart_rfd;
    tdat = uart_din;
    tsrc = oh_idx(grant);
    @(posedge clk);
    #1;
    if (take && !rst && out_n < 64) begin
      out_rec[out_n] = {tsrc, tdat};
      out_n++;
    end
    for (int i = 0; i < N; i++) if (acc[i]) src_ptr[i]++;
    drive();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    uart_rfd = 1'b1;
    for (int i = 0; i < N; i++) begin
      src_len[i] = 0;
      src_ptr[i] = 0;
    end
    out_n = 0;
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_done(input string tag, input int n, input int bound);
    int k = 0;
    while ((out_n < n || busy) && k < bound) begin
      step();
      k++;
    end
    check(tag, out_n, n);
  endtask

  initial begin
    int k;
    int bad_din, bad_vld, bad_rdy;
    logic [11:0] exp3 [12];
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    uart_rfd = 1'b0;
    out_n    = 0;
    for (int i = 0; i < N; i++) begin
      src_len[i] = 0;
      src_ptr[i] = 0;
    end
    drive();

    // Reset values
    @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_rdy", req_rdy, 0);
    check("rst_din", uart_din, 0);
    check("rst_vld", uart_din_vld, 0);
    check("rst_busy", busy, 0);

    // Single message from requester 2, UART always ready
    do_reset();
    push(2, 8'hA1, 1'b0); push(2, 8'hB2, 1'b0); push(2, 8'hC3, 1'b1);
    drive();
    step();
    check("t1_grant", grant, 4'b0100);
    check("t1_rdy", req_rdy, 4'b0100);
    step();
    check("t1_vld", uart_din_vld, 1);
    check("t1_din", uart_din, 8'hA1);
    check("t1_rdy_low", req_rdy, 0);
    run_done("t1_count", 3, 60);
    check("t1_b0", out_rec[0], 12'h2A1);
    check("t1_b1", out_rec[1], 12'h2B2);
    check("t1_b2", out_rec[2], 12'h2C3);
    check("t1_grant_end", grant, 0);
    check("t1_busy_end", busy, 0);

    // Round robin between requesters 0 and 1, two 2-byte messages each
    do_reset();
    push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b1); push(0, 8'h12, 1'b0); push(0, 8'h13, 1'b1);
    push(1, 8'h20, 1'b0); push(1, 8'h21, 1'b1); push(1, 8'h22, 1'b0); push(1, 8'h23, 1'b1);
    drive();
    run_done("t2_count", 8, 200);
    check("t2_b0", out_rec[0], 12'h010);
    check("t2_b1", out_rec[1], 12'h011);
    check("t2_b2", out_rec[2], 12'h120);
    check("t2_b3", out_rec[3], 12'h121);
    check("t2_b4", out_rec[4], 12'h012);
    check("t2_b5", out_rec[5], 12'h013);
    check("t2_b6", out_rec[6], 12'h122);
    check("t2_b7", out_rec[7], 12'h123);

    // Burst limit of 4: requester 3 streams 10 bytes, requester 0 cuts in
    do_reset();
    for (int b = 0; b < 10; b++) push(3, 8'(8'h30 + b), 1'b0);
    drive();
    k = 0;
    while (grant !== 4'b1000 && k < 10) begin step(); k++; end
    check("t3_grant3", grant, 4'b1000);
    push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b1);
    drive();
    run_done("t3_count", 12, 400);
    exp3 = '{12'h330, 12'h331, 12'h332, 12'h333, 12'h001, 12'h002,
             12'h334, 12'h335, 12'h336, 12'h337, 12'h338, 12'h339};
    for (int b = 0; b < 12; b++) check($sformatf("t3_b%0d", b), out_rec[b], exp3[b]);

    // Idle timeout of 8: requester 1 stalls after one byte without last
    do_reset();
    push(1, 8'h55, 1'b0);
    drive();
    k = 0;
    while (grant !== 4'b0010 && k < 10) begin step(); k++; end
    check("t4_grant1", grant, 4'b0010);
    push(2, 8'h66, 1'b1);
    drive();
    k = 0;
    while (uart_din_vld !== 1'b1 && k < 10) begin step(); k++; end
    check("t4_held", uart_din_vld, 1);
    k = 0;
    while (uart_din_vld !== 1'b0 && k < 10) begin step(); k++; end
    k = 0;
    do begin step(); k++; end while (req_rdy != 0 && k < 40);
    check("t4_drain_cycles", k, 8);
    step();
    check("t4_release", grant, 0);
    step();
    check("t4_grant2", grant, 4'b0100);
    check("t4_byte", out_rec[0], 12'h155);

    // Backpressure: UART not ready for 100 cycles with a byte held
    do_reset();
    uart_rfd = 1'b0;
    push(0, 8'h77, 1'b0); push(0, 8'h78, 1'b1);
    drive();
    k = 0;
    while (uart_din_vld !== 1'b1 && k < 10) begin step(); k++; end
    bad_din = 0; bad_vld = 0; bad_rdy = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (uart_din !== 8'h77) bad_din++;
      if (uart_din_vld !== 1'b1) bad_vld++;
      if (req_rdy !== '0) bad_rdy++;
    end
    check("t5_din_stable", bad_din, 0);
    check("t5_vld_stable", bad_vld, 0);
    check("t5_rdy_low", bad_rdy, 0);
    uart_rfd = 1'b1;
    step();
    check("t5_taken_vld", uart_din_vld, 0);
    check("t5_taken_cnt", out_n, 1);
    check("t5_b0", out_rec[0], 12'h077);
    run_done("t5_count", 2, 50);
    check("t5_b1", out_rec[1], 12'h078);

    // Reset while byte 2 of 5 is held; requester 0 first again afterwards
    do_reset();
    uart_rfd = 1'b0;
    for (int b = 0; b < 5; b++) push(0, 8'(8'h90 + b), (b == 4));
    push(1, 8'hA0, 1'b1);
    drive();
    k = 0;
    while (uart_din_vld !== 1'b1 && k < 10) begin step(); k++; end
    uart_rfd = 1'b1;
    step();
    uart_rfd = 1'b0;
    k = 0;
    while (!(uart_din_vld === 1'b1 && uart_din === 8'h91) && k < 10) begin step(); k++; end
    check("t6_held", uart_din, 8'h91);
    rst = 1'b1;
    #1;
    check("t6_grant", grant, 0);
    check("t6_rdy", req_rdy, 0);
    check("t6_din", uart_din, 0);
    check("t6_vld", uart_din_vld, 0);
    check("t6_busy", busy, 0);
    step();
    rst = 1'b0;
    uart_rfd = 1'b1;
    k = 0;
    while (grant === '0 && k < 10) begin step(); k++; end
    check("t6_first", grant, 4'b0001);
    k = 0;
    while (uart_din_vld !== 1'b1 && k < 10) begin step(); k++; end
    check("t6_resume", uart_din, 8'h92);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
